// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: default widths, the reset fetch address,
// the {inst, pc} entry record used by the prefetch queue and the instruction
// register, and a counter-width helper.
package fetch_pkg;

  localparam int FETCH_INST_W = 67;
  localparam int FETCH_ADDR_W = 32;
  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = '0;

  typedef struct packed {
    logic [FETCH_INST_W-1:0] inst;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

  // Occupancy counters must hold the value DEPTH itself, hence the extra bit.
  function automatic int fetch_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_sync_fifo.sv
// Single-clock in-order FIFO with push, pop, synchronous clear and an
// occupancy count. DEPTH must be a power of two (>= 2) so the pointers wrap
// naturally. A pop and a push on the last free slot may share a cycle.
module fetch_sync_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = fetch_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CNT_W'(DEPTH)) || pop_ok);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; clear empties the queue in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Entry storage carries no reset; only the occupancy count qualifies it
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch-stage prefetch queue. Issues sequential fetch addresses under a
// credit scheme (buffered + in-flight never exceeds DEPTH), buffers returned
// instruction words with their addresses and presents the head entry to the
// instruction register. A redirect flushes everything buffered and marks all
// in-flight responses for discard.
// Optional build macro FETCH_PERF_CNT_EN adds bubble_cnt and flush_cnt.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int                INST_W   = FETCH_INST_W,
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ir_wr,
  output logic [INST_W-1:0] ir_inst,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_take
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       bubble_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam int CNT_W = fetch_cnt_w(DEPTH);
  localparam int ENT_W = INST_W + ADDR_W;

  logic [ADDR_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  outstanding_nxt;
  logic [CNT_W-1:0]  discard;
  logic [CNT_W-1:0]  inst_count;
  logic [CNT_W-1:0]  addr_count;
  logic [CNT_W:0]    credit_used;
  logic [ADDR_W-1:0] resp_pc;
  logic [ENT_W-1:0]  head_entry;
  logic              xfer;
  logic              resp_live;
  logic              resp_keep;
  logic              resp_drop;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign resp_live = mem_rvalid && (outstanding != '0);
  assign resp_keep = resp_live && (discard == '0);
  assign resp_drop = resp_live && (discard != '0);

  assign credit_used = {1'b0, inst_count} + {1'b0, outstanding};
  assign mem_req     = !rst && !redirect && (credit_used < (CNT_W+1)'(DEPTH));
  assign mem_addr    = fetch_pc;
  assign xfer        = mem_req && mem_gnt;

  assign outstanding_nxt = outstanding + CNT_W'(xfer) - CNT_W'(resp_live);

  // Addresses of requests still awaiting a kept response, in issue order.
  fetch_sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_addr_q (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (xfer),
    .push_data (fetch_pc),
    .pop       (resp_keep),
    .head      (resp_pc),
    .count     (addr_count)
  );

  // Returned instruction words paired with their fetch address.
  fetch_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_inst_q (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (resp_keep && !redirect),
    .push_data ({mem_rdata, resp_pc}),
    .pop       (ir_take && ir_wr && !redirect),
    .head      (head_entry),
    .count     (inst_count)
  );

  assign ir_wr   = (inst_count != '0);
  assign ir_inst = ir_wr ? head_entry[ENT_W-1:ADDR_W] : '0;
  assign ir_pc   = ir_wr ? head_entry[ADDR_W-1:0]     : '0;

  // Fetch address, in-flight credit and discard bookkeeping. A redirect marks
  // every request still in flight after this cycle as stale; a response that
  // lands in the redirect cycle itself is dropped along with the flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        discard  <= outstanding_nxt;
      end else begin
        if (xfer)      fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        if (resp_drop) discard  <= discard - 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  // Saturating counts of empty-head cycles and accepted redirects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (!ir_wr)   bubble_cnt <= sat_inc32(bubble_cnt);
      if (redirect) flush_cnt  <= sat_inc16(flush_cnt);
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    !(mem_rvalid && (outstanding == '0)));
  a_addr_q_tracks_kept: assert property (@(posedge clk) disable iff (rst)
    addr_count == (outstanding - discard));
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: a latency-programmable in-order memory
// model, an expected-entry scoreboard filled when requests are granted and
// drained when the instruction register takes the head, a per-cycle vector
// table for the credit/fill sequence, and hand-written redirect sequences.
module tb_fetch_prefetch_queue;

  localparam int INST_W = 67;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [INST_W-1:0] mem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              ir_wr;
  logic [INST_W-1:0] ir_inst;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_take;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       bubble_cnt;
  logic [15:0]       flush_cnt;
`endif

  always #5 clk = ~clk;

  fetch_prefetch_queue #(
    .INST_W   (INST_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .PC_STEP  (1),
    .RESET_PC ('0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ir_wr       (ir_wr),
    .ir_inst     (ir_inst),
    .ir_pc       (ir_pc),
    .ir_take     (ir_take)
`ifdef FETCH_PERF_CNT_EN
    ,
    .bubble_cnt  (bubble_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                due;
  } mreq_t;

  typedef struct {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } exp_t;

  typedef struct {
    bit                take;
    bit                gnt;
    bit                e_req;
    logic [ADDR_W-1:0] e_addr;
    bit                e_wr;
  } vec_t;

  mreq_t             mq[$];
  exp_t              exp_q[$];
  logic [ADDR_W-1:0] acc_log[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc;
  int lat;
  int nacc;
  int npop;

  bit                gnt_i;
  bit                take_i;
  bit                redir_i;
  logic [ADDR_W-1:0] rpc_i;
  logic [ADDR_W-1:0] model_pc;

  logic              s_req;
  logic              s_wr;
  logic [ADDR_W-1:0] s_pc;

  function automatic logic [INST_W-1:0] gen(input logic [ADDR_W-1:0] a);
    return {3'b101, a ^ 32'hA5A5_5A5A, a};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Assert reset at a falling edge, check the reset-state outputs, release.
  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    ir_take     = 1'b0;
    mq.delete();
    exp_q.delete();
    model_pc = '0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ir_wr", ir_wr, 0);
    chk("rst_ir_inst", ir_inst, 0);
    chk("rst_ir_pc", ir_pc, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  // One clock cycle: drive inputs and the memory response at the falling
  // edge, sample combinational outputs 1 time unit later, update the models.
  task automatic tick();
    @(negedge clk);
    mem_gnt     = gnt_i;
    ir_take     = take_i;
    redirect    = redir_i;
    redirect_pc = rpc_i;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = gen(mq[0].addr);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
    #1;
    s_req = mem_req;
    s_wr  = ir_wr;
    s_pc  = ir_pc;
    if (redir_i) begin
      chk("req_in_redirect", mem_req, 0);
      exp_q.delete();
      model_pc = rpc_i;
    end else begin
      if (mem_req && mem_gnt) begin
        chk("issue_addr", mem_addr, model_pc);
        mq.push_back('{addr: mem_addr, due: cyc + lat});
        exp_q.push_back('{inst: gen(mem_addr), pc: mem_addr});
        acc_log.push_back(mem_addr);
        model_pc = model_pc + 1;
        nacc++;
      end
      if (ir_wr && ir_take) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_pop: got pc %0h, expected no entry", ir_pc);
        end else begin
          chk("pop_pc", ir_pc, exp_q[0].pc);
          chk("pop_inst", ir_inst, exp_q[0].inst);
          void'(exp_q.pop_front());
        end
        npop++;
      end
    end
    if (mem_rvalid) void'(mq.pop_front());
    cyc++;
  endtask

  vec_t tbl[12];

  initial begin
    int                bubble;
    int                stale;
    bit                seen;
    logic [ADDR_W-1:0] first_pc;

    rst         = 1'b1;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    ir_take     = 1'b0;
    gnt_i = 0; take_i = 0; redir_i = 0; rpc_i = '0;
    lat = 1; cyc = 0; nacc = 0; npop = 0;

    // Streaming: 1-cycle memory, consumer always ready.
    do_reset();
    lat = 1; gnt_i = 1; take_i = 1; nacc = 0; npop = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("stream_issues", nacc, 20);
    chk("stream_pops", npop, 18);
    take_i = 0; gnt_i = 0;
    for (int i = 0; i < 3; i++) tick();

    // Fill to DEPTH with the consumer stalled, then single-credit behaviour.
    tbl[0]  = '{0, 1, 1, 32'h0, 0};
    tbl[1]  = '{0, 1, 1, 32'h1, 0};
    tbl[2]  = '{0, 1, 1, 32'h2, 1};
    tbl[3]  = '{0, 1, 1, 32'h3, 1};
    tbl[4]  = '{0, 1, 0, 32'h0, 1};
    tbl[5]  = '{0, 1, 0, 32'h0, 1};
    tbl[6]  = '{1, 1, 0, 32'h0, 1};
    tbl[7]  = '{0, 1, 1, 32'h4, 1};
    tbl[8]  = '{1, 1, 0, 32'h0, 1};
    tbl[9]  = '{0, 1, 1, 32'h5, 1};
    tbl[10] = '{0, 1, 0, 32'h0, 1};
    tbl[11] = '{0, 1, 0, 32'h0, 1};
    do_reset();
    lat = 1; nacc = 0; npop = 0;
    for (int i = 0; i < 12; i++) begin
      take_i = tbl[i].take;
      gnt_i  = tbl[i].gnt;
      tick();
      chk($sformatf("tbl%0d_req", i), s_req, tbl[i].e_req);
      chk($sformatf("tbl%0d_wr", i), s_wr, tbl[i].e_wr);
      if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
      if (i == 5) chk("fill_issues", nacc, 4);
    end
    take_i = 1;
    for (int i = 0; i < 12; i++) tick();
    chk("fill_total_issues", nacc > 6, 1);

    // Redirect with three requests in flight, 3-cycle memory.
    do_reset();
    lat = 3; gnt_i = 1; take_i = 1;
    for (int i = 0; i < 3; i++) tick();
    redir_i = 1; rpc_i = 32'h100;
    tick();
    redir_i = 0;
    seen = 0; bubble = 0; first_pc = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (!seen) begin
        if (s_wr) begin
          seen = 1;
          first_pc = s_pc;
        end else begin
          bubble++;
        end
      end
    end
    chk("redir1_seen", seen, 1);
    chk("redir1_first_pc", first_pc, 32'h100);
    chk("redir1_bubble", bubble, 4);

    // Redirect while granting, then a second redirect during discard.
    do_reset();
    lat = 3; gnt_i = 1; take_i = 1;
    for (int i = 0; i < 3; i++) tick();
    redir_i = 1; rpc_i = 32'h200;
    tick();
    redir_i = 0;
    tick();
    redir_i = 1; rpc_i = 32'h300;
    tick();
    redir_i = 0;
    seen = 0; stale = 0; first_pc = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (s_wr && (s_pc < 32'h300 || s_pc > 32'h310)) stale++;
      if (s_wr && !seen) begin
        seen = 1;
        first_pc = s_pc;
      end
    end
    chk("redir2_stale", stale, 0);
    chk("redir2_seen", seen, 1);
    chk("redir2_first_pc", first_pc, 32'h300);

    // Fetch address wraps at the top of the address space.
    do_reset();
    lat = 1; gnt_i = 1; take_i = 1;
    redir_i = 1; rpc_i = 32'hFFFF_FFFF;
    tick();
    redir_i = 0;
    acc_log.delete();
    for (int i = 0; i < 6; i++) tick();
    chk("wrap_issues", acc_log.size(), 6);
    if (acc_log.size() >= 2) begin
      chk("wrap_addr0", acc_log[0], 32'hFFFF_FFFF);
      chk("wrap_addr1", acc_log[1], 32'h0);
    end

    // Reset asserted mid-stream clears the head immediately.
    chk("pre_rst_wr", s_wr, 1);
    do_reset();

`ifdef FETCH_PERF_CNT_EN
    gnt_i = 0; take_i = 0; redir_i = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("perf_bubble", bubble_cnt, 5);
    redir_i = 1; rpc_i = 32'h40;
    tick();
    tick();
    redir_i = 0;
    tick();
    chk("perf_flush", flush_cnt, 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("perf_rst_bubble", bubble_cnt, 0);
    chk("perf_rst_flush", flush_cnt, 0);
    chk("perf_rst_wr", ir_wr, 0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
